tia_f1: RTL and testbench



---
 rtl/tia_f1.sv | 29 ++
 tb/tb_tia_f1.sv | 130 +++++++++++++
 2 files changed

// File: rtl/tia_f1.sv
// Clocked set/reset flip-flop (TIA "F1" cell): active-low set and clear,
// synchronous active-high reset, complementary outputs from one stored bit.
module tia_f1 (
  input  logic clock,
  input  logic reset,
  input  logic s,
  input  logic r,
  output logic q,
  output logic q_bar
);

  logic q_reg;

  // Priority: reset, then clear, then set; otherwise hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      q_reg <= 1'b0;
    end else if (!r) begin
      q_reg <= 1'b0;
    end else if (!s) begin
      q_reg <= 1'b1;
    end
  end

  // q_bar is derived from the same bit so the two outputs can never disagree.
  assign q     = q_reg;
  assign q_bar = ~q_reg;

endmodule

// File: tb/tb_tia_f1.sv
// Self-checking bench for tia_f1: directed literal checks plus a per-cycle
// comparison against a rule-table model of the flip-flop.
module tb_tia_f1;

  logic clock;
  logic reset;
  logic s;
  logic r;
  logic q;
  logic q_bar;

  int total;
  int bad;

  tia_f1 dut (
    .clock (clock),
    .reset (reset),
    .s     (s),
    .r     (r),
    .q     (q),
    .q_bar (q_bar)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Rule table indexed by {reset, r, s}: 0 = clear, 1 = set, 2 = hold.
  int   rule [8];
  logic model_q;
  logic model_known;

  initial begin
    rule[0] = 0; rule[1] = 0; rule[2] = 1; rule[3] = 2;
    rule[4] = 0; rule[5] = 0; rule[6] = 0; rule[7] = 0;
    model_q     = 1'b0;
    model_known = 1'b0;
  end

  always @(posedge clock) begin
    int act;
    act = rule[{reset, r, s}];
    if (act == 0) model_q <= 1'b0;
    else if (act == 1) model_q <= 1'b1;
    if (reset) model_known <= 1'b1;
  end

  // Compare process: every cycle once the model state is defined.
  always @(posedge clock) begin
    #1;
    if (model_known) begin
      total++;
      if (q !== model_q || q_bar !== ~model_q) begin
        bad++;
        $display("FAIL model_cmp t=%0t q=%b q_bar=%b required q=%b q_bar=%b",
                 $time, q, q_bar, model_q, ~model_q);
      end
    end
  end

  task automatic check_lit(input string name, input logic exp_q);
    total++;
    if (q !== exp_q || q_bar !== ~exp_q) begin
      bad++;
      $display("FAIL %s q=%b q_bar=%b required q=%b q_bar=%b",
               name, q, q_bar, exp_q, ~exp_q);
    end else begin
      $display("ok   %s q=%b q_bar=%b", name, q, q_bar);
    end
  endtask

  task automatic step(input string name, input logic rst, input logic sv,
                      input logic rv, input logic exp_q);
    @(negedge clock);
    reset = rst;
    s     = sv;
    r     = rv;
    @(posedge clock);
    #2;
    check_lit(name, exp_q);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    s     = 1'b1;
    r     = 1'b1;

    step("reset",          1'b1, 1'b1, 1'b1, 1'b0);
    step("set",            1'b0, 1'b0, 1'b1, 1'b1);
    step("hold_set",       1'b0, 1'b1, 1'b1, 1'b1);
    step("clear",          1'b0, 1'b1, 1'b0, 1'b0);
    step("hold_clear",     1'b0, 1'b1, 1'b1, 1'b0);
    step("set_again",      1'b0, 1'b0, 1'b1, 1'b1);
    step("rst_over_set",   1'b1, 1'b0, 1'b1, 1'b0);
    step("rst_over_idle",  1'b1, 1'b1, 1'b1, 1'b0);
    step("rst_over_clear", 1'b1, 1'b1, 1'b0, 1'b0);
    step("rst_over_idle2", 1'b1, 1'b1, 1'b1, 1'b0);
    step("set_after_rst",  1'b0, 1'b0, 1'b1, 1'b1);
    step("clear_priority", 1'b0, 1'b0, 1'b0, 1'b0);
    step("idle_zero",      1'b0, 1'b1, 1'b1, 1'b0);

    // Set pulse that starts and ends between two rising edges.
    @(negedge clock);
    s = 1'b0;
    #2;
    s = 1'b1;
    @(posedge clock);
    #2;
    check_lit("edge_sampling", 1'b0);

    // Random traffic, checked by the model compare process.
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      reset = ($urandom_range(0, 15) == 0);
      s     = $urandom_range(0, 1);
      r     = ($urandom_range(0, 3) != 0);
    end
    @(negedge clock);
    reset = 1'b0;
    s     = 1'b1;
    r     = 1'b1;
    repeat (2) @(posedge clock);
    #3;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
